// File: rtl/sprite_pkg.sv
`timescale 1ns/1ps
// sprite_pkg: shared default sizes and the tag-width helper for the
// sprite ROM arbiter and its winner-selection sub-module.
package sprite_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int AW_DEF    = 16;
    localparam int DW_DEF    = 24;
    localparam int TAG_W     = $clog2(N_REQ_DEF);

    // Width of a channel index; never narrower than one bit.
    function automatic int tag_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_arb_pick.sv
`timescale 1ns/1ps
// sprite_arb_pick: combinational winner search. Scans the eligible vector
// starting at (ptr+1) mod N_REQ and returns the first hit as a one-hot
// vector plus its index. A pointer of N_REQ-1 gives lowest-index-first.
module sprite_arb_pick
    import sprite_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int TW    = TAG_W
) (
    input  logic [N_REQ-1:0] elig,
    input  logic [TW-1:0]    ptr,
    output logic [N_REQ-1:0] win_oh,
    output logic [TW-1:0]    win_idx,
    output logic             win_vld
);

    // Rotating first-hit search over the eligible channels.
    always_comb begin
        int          idx;
        logic [TW-1:0] sel;
        win_oh  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            sel = TW'(idx);
            if (!win_vld && elig[sel]) begin
                win_vld      = 1'b1;
                win_idx      = sel;
                win_oh[sel]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
`timescale 1ns/1ps
// sprite_rom_arbiter: shares one single-port, one-cycle-latency sprite ROM
// among N_REQ channels. Each channel has at most one read outstanding; the
// winner index travels as a tag and returns with the pixel two cycles
// after its grant. Define SPRITE_ARB_ROUND_ROBIN_EN for round-robin
// arbitration; otherwise fixed priority, lowest index wins.
module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*AW-1:0] addr,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    rd_valid,
    output logic [DW-1:0]       rd_data,
    output logic                rom_rd,
    output logic [AW-1:0]       rom_addr,
    input  logic [DW-1:0]       rom_data,
    output logic                busy
);

    localparam int TW = tag_width(N_REQ);

    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] pending_nxt;
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] win_oh;
    logic [TW-1:0]    win_idx;
    logic             win_vld;
    logic [TW-1:0]    ptr;
    logic [AW-1:0]    sel_addr;
    logic [N_REQ-1:0] ret_oh;

    logic             vld_p0;
    logic [TW-1:0]    tag_p0;
    logic             vld_p1;
    logic [TW-1:0]    tag_p1;

    assign elig   = req & ~gnt & ~pending;
    assign rom_rd = vld_p0;

    sprite_arb_pick #(
        .N_REQ (N_REQ),
        .TW    (TW)
    ) u_pick (
        .elig    (elig),
        .ptr     (ptr),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .win_vld (win_vld)
    );

`ifdef SPRITE_ARB_ROUND_ROBIN_EN
    // Last-winner pointer; search starts one past it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= TW'(N_REQ - 1);
        end else if (win_vld) begin
            ptr <= win_idx;
        end
    end
`else
    assign ptr = TW'(N_REQ - 1);
`endif

    // Address mux for the winning channel, and the return one-hot from the tag.
    always_comb begin
        sel_addr = '0;
        ret_oh   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_oh[i]) begin
                sel_addr = addr[i*AW +: AW];
            end
        end
        if (vld_p1) begin
            ret_oh[tag_p1] = 1'b1;
        end
        pending_nxt = (pending & ~ret_oh) | win_oh;
    end

    // Grant/issue stage (p0), ROM-access stage (p1), return stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt      <= '0;
            vld_p0   <= 1'b0;
            tag_p0   <= '0;
            rom_addr <= '0;
            vld_p1   <= 1'b0;
            tag_p1   <= '0;
            rd_valid <= '0;
            rd_data  <= '0;
            pending  <= '0;
            busy     <= 1'b0;
        end else begin
            // p0: grant and ROM request
            gnt    <= win_oh;
            vld_p0 <= win_vld;
            tag_p0 <= win_idx;
            if (win_vld) begin
                rom_addr <= sel_addr;
            end
            // p1: ROM data arrives during this cycle
            vld_p1 <= vld_p0;
            tag_p1 <= tag_p0;
            // return: capture pixel and strobe the tagged channel
            rd_valid <= ret_oh;
            if (vld_p1) begin
                rd_data <= rom_data;
            end
            pending <= pending_nxt;
            busy    <= |pending_nxt;
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
`timescale 1ns/1ps
// tb_sprite_rom_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level reference model (grant time, due time, ROM
// contents as a function of address).
module tb_sprite_rom_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 24;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*AW-1:0] addr;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rd_valid;
    logic [DW-1:0]   rd_data;
    logic            rom_rd;
    logic [AW-1:0]   rom_addr;
    logic [DW-1:0]   rom_data;
    logic            busy;

    int n_cmp = 0;
    int n_bad = 0;

    sprite_rom_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .addr     (addr),
        .gnt      (gnt),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rom_rd   (rom_rd),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Sprite ROM contents as a pure function of the address.
    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
        if (a == 16'h0123) return 24'hAABBCC;
        return {a[7:0] ^ 8'h5A, a[15:8] + 8'h11, ~a[7:0]};
    endfunction

    // External one-cycle-latency ROM.
    always @(posedge clk) begin
        if (rom_rd) rom_data <= rom_f(rom_addr);
    end

    // ---------------- reference model ----------------
    logic [N-1:0]  m_gnt;
    logic [N-1:0]  m_rdv;
    logic          m_rd;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic          m_busy;
    int            due [N];
    logic [AW-1:0] m_raddr [N];
    int            m_last;
    int            cyc;

    task automatic model_reset();
        m_gnt = '0; m_rdv = '0; m_rd = 1'b0; m_addr = '0; m_data = '0;
        m_busy = 1'b0; m_last = N - 1; cyc = 0;
        for (int i = 0; i < N; i++) begin
            due[i] = -1;
            m_raddr[i] = '0;
        end
    endtask

    task automatic model_edge(input logic [N-1:0] r, input logic [N*AW-1:0] a);
        int w;
        int c;
        cyc++;
        w = -1;
        for (int k = 0; k < N; k++) begin
`ifdef SPRITE_ARB_ROUND_ROBIN_EN
            c = (m_last + 1 + k) % N;
`else
            c = k;
`endif
            if (w < 0 && r[c] && !m_gnt[c] && due[c] < 0) w = c;
        end
        m_rdv = '0;
        for (int i = 0; i < N; i++) begin
            if (due[i] == cyc) begin
                m_rdv[i] = 1'b1;
                m_data = rom_f(m_raddr[i]);
                due[i] = -1;
            end
        end
        m_gnt = '0;
        m_rd = 1'b0;
        if (w >= 0) begin
            m_gnt[w] = 1'b1;
            m_rd = 1'b1;
            m_addr = a[w*AW +: AW];
            m_raddr[w] = m_addr;
            due[w] = cyc + 2;
            m_last = w;
        end
        m_busy = 1'b0;
        for (int i = 0; i < N; i++) if (due[i] >= 0) m_busy = 1'b1;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".gnt"},      64'(gnt),      64'(m_gnt));
        chk({tag, ".rom_rd"},   64'(rom_rd),   64'(m_rd));
        chk({tag, ".rom_addr"}, 64'(rom_addr), 64'(m_addr));
        chk({tag, ".rd_valid"}, 64'(rd_valid), 64'(m_rdv));
        chk({tag, ".busy"},     64'(busy),     64'(m_busy));
        if (m_rdv != '0) chk({tag, ".rd_data"}, 64'(rd_data), 64'(m_data));
    endtask

    task automatic step(input string tag, input logic [N-1:0] r, input logic [N*AW-1:0] a);
        req = r;
        addr = a;
        @(posedge clk);
        model_edge(r, a);
        #1;
        compare_all(tag);
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    logic [N-1:0]    cur_req;
    logic [N*AW-1:0] cur_addr;
    logic [AW-1:0]   saved_addr;
    int              g2cnt;
    int              g2last;
    int              exp_w;

    initial begin
        // Reset state
        rst = 1'b1; req = '0; addr = '0; rom_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.gnt",      64'(gnt),      64'd0);
        chk("rst.rd_valid", 64'(rd_valid), 64'd0);
        chk("rst.rd_data",  64'(rd_data),  64'd0);
        chk("rst.rom_rd",   64'(rom_rd),   64'd0);
        chk("rst.rom_addr", 64'(rom_addr), 64'd0);
        chk("rst.busy",     64'(busy),     64'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step("idle0", '0, '0);

        // Single read of address 0x0123
        cur_addr = '0;
        cur_addr[0*AW +: AW] = 16'h0123;
        step("single", 4'b0001, cur_addr);
        chk("single.gnt0",     64'(gnt),      64'h1);
        chk("single.rom_addr", 64'(rom_addr), 64'h0123);
        chk("single.rom_rd",   64'(rom_rd),   64'h1);
        step("single", '0, cur_addr);
        chk("single.no_rdv",   64'(rd_valid), 64'h0);
        step("single", '0, cur_addr);
        chk("single.rdv0",     64'(rd_valid), 64'h1);
        chk("single.rd_data",  64'(rd_data),  64'hAABBCC);
        step("single", '0, cur_addr);

        // Sustained single requester on channel 2
        cur_addr = '0;
        cur_addr[2*AW +: AW] = 16'h2222;
        g2cnt = 0;
        g2last = -10;
        for (int i = 1; i <= 12; i++) begin
            step("ch2", 4'b0100, cur_addr);
            if (gnt[2]) begin
                if (g2cnt > 0) chk("ch2.spacing", 64'(i - g2last), 64'd3);
                g2cnt++;
                g2last = i;
            end
        end
        chk("ch2.count", 64'(g2cnt), 64'd4);
        for (int i = 0; i < 3; i++) step("drain", '0, cur_addr);

        // All four channels held high
        for (int i = 0; i < N; i++) cur_addr[i*AW +: AW] = AW'(16'h4000 + i);
        for (int i = 0; i < 12; i++) begin
            step("all", 4'b1111, cur_addr);
`ifdef SPRITE_ARB_ROUND_ROBIN_EN
            exp_w = i % 4;
`else
            exp_w = i % 3;
`endif
            chk("all.winner", 64'(oh_idx(gnt)), 64'(exp_w));
            chk("all.rom_rd", 64'(rom_rd), 64'd1);
        end
        for (int i = 0; i < 3; i++) step("drain", '0, cur_addr);

        // Reset in the cycle after a grant to channel 1
        cur_addr[1*AW +: AW] = 16'h0BEE;
        step("rstmid", 4'b0010, cur_addr);
        chk("rstmid.gnt1", 64'(gnt), 64'h2);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rstmid.gnt",      64'(gnt),      64'd0);
        chk("rstmid.rd_valid", 64'(rd_valid), 64'd0);
        chk("rstmid.rd_data",  64'(rd_data),  64'd0);
        chk("rstmid.rom_rd",   64'(rom_rd),   64'd0);
        chk("rstmid.rom_addr", 64'(rom_addr), 64'd0);
        chk("rstmid.busy",     64'(busy),     64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step("rstmid.after", '0, cur_addr);
            chk("rstmid.no_rdv1", 64'(rd_valid[1]), 64'd0);
        end

        // Randomized traffic honouring the address-stability rule
        cur_req = '0;
        cur_addr = '0;
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!(cur_req[i] && !m_gnt[i])) begin
                    cur_req[i] = ($urandom_range(0, 3) != 0);
                    cur_addr[i*AW +: AW] = AW'($urandom);
                end
            end
            step("rand", cur_req, cur_addr);
        end
        for (int i = 0; i < 4; i++) step("drain", '0, cur_addr);

        // Idle for 10 cycles: nothing issued, address held
        saved_addr = m_addr;
        for (int i = 0; i < 10; i++) begin
            step("idle", '0, $urandom);
            chk("idle.rom_rd",   64'(rom_rd),   64'd0);
            chk("idle.gnt",      64'(gnt),      64'd0);
            chk("idle.busy",     64'(busy),     64'd0);
            chk("idle.rom_addr", 64'(rom_addr), 64'(saved_addr));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
